// File: rtl/mem_arb.sv
// Two-port memory arbiter: instruction fetch and data access share one
// single-cycle-latency memory, with anti-starvation for the fetch port.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module mem_arb #(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 2
) (
    input  logic                  iw_clk,
    input  logic                  iw_rst,
    input  logic                  iw_i_req,
    input  logic [`SIZE_ADDR-1:0] iw_i_addr,
    output logic                  ow_i_gnt,
    output logic                  ow_i_stall,
    output logic                  ow_i_rvalid,
    output logic [`SIZE_DATA-1:0] ow_i_rdata,
    input  logic                  iw_d_req,
    input  logic                  iw_d_we,
    input  logic [`SIZE_ADDR-1:0] iw_d_addr,
    input  logic [`SIZE_DATA-1:0] iw_d_wdata,
    output logic                  ow_d_gnt,
    output logic                  ow_d_stall,
    output logic                  ow_d_rvalid,
    output logic [`SIZE_DATA-1:0] ow_d_rdata,
    output logic                  ow_mem_we,
    output logic [`SIZE_ADDR-1:0] ow_mem_addr,
    output logic [`SIZE_DATA-1:0] ow_mem_wdata,
    input  logic [`SIZE_DATA-1:0] iw_mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(STARVE_MAX);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_starve;
    owner_e           r_owner;
    owner_e           w_owner_nxt;
    logic             w_i_gnt;
    logic             w_d_gnt;
    logic             w_starved;

    // Data wins ties until the fetch port has been denied STARVE_MAX times.
    always_comb begin
        w_starved = (r_starve >= LP_MAX);
        w_i_gnt   = iw_i_req & (~iw_d_req | w_starved);
        w_d_gnt   = iw_d_req & ~w_i_gnt;
    end

    assign ow_i_gnt   = w_i_gnt;
    assign ow_d_gnt   = w_d_gnt;
    assign ow_i_stall = iw_i_req & ~w_i_gnt;
    assign ow_d_stall = iw_d_req & ~w_d_gnt;

    always_comb begin
        ow_mem_addr  = '0;
        ow_mem_wdata = '0;
        ow_mem_we    = 1'b0;
        if (w_d_gnt) begin
            ow_mem_addr  = iw_d_addr;
            ow_mem_wdata = iw_d_wdata;
            ow_mem_we    = iw_d_we & ~iw_rst;
        end else if (w_i_gnt) begin
            ow_mem_addr = iw_i_addr;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_starve <= '0;
        end else if (w_i_gnt) begin
            r_starve <= '0;
        end else if (iw_i_req && (r_starve < LP_MAX)) begin
            r_starve <= r_starve + LP_ONE;
        end
    end

    // Writes leave no owner, so they never raise a read-valid.
    always_comb begin
        w_owner_nxt = OWN_NONE;
        if (w_i_gnt) begin
            w_owner_nxt = OWN_I;
        end else if (w_d_gnt && !iw_d_we) begin
            w_owner_nxt = OWN_D;
        end
    end

    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= w_owner_nxt;
        end
    end

    assign ow_i_rvalid = (r_owner == OWN_I);
    assign ow_d_rvalid = (r_owner == OWN_D);
    assign ow_i_rdata  = ow_i_rvalid ? iw_mem_rdata : '0;
    assign ow_d_rdata  = ow_d_rvalid ? iw_mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Directed vector bench for mem_arb with a small registered memory model.
module tb_mem_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_gnt, i_stall, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_gnt, d_stall, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_arb #(.STARVE_MAX(3), .CNT_W(2)) dut (
        .iw_clk(clk), .iw_rst(rst),
        .iw_i_req(i_req), .iw_i_addr(i_addr),
        .ow_i_gnt(i_gnt), .ow_i_stall(i_stall),
        .ow_i_rvalid(i_rvalid), .ow_i_rdata(i_rdata),
        .iw_d_req(d_req), .iw_d_we(d_we),
        .iw_d_addr(d_addr), .iw_d_wdata(d_wdata),
        .ow_d_gnt(d_gnt), .ow_d_stall(d_stall),
        .ow_d_rvalid(d_rvalid), .ow_d_rdata(d_rdata),
        .ow_mem_we(mem_we), .ow_mem_addr(mem_addr),
        .ow_mem_wdata(mem_wdata), .iw_mem_rdata(mem_rdata)
    );

    logic [31:0] mem [0:255];

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // g/rv: 0 none, 1 instruction port, 2 data port
    typedef struct {
        logic        ir;
        logic [7:0]  ia;
        logic        dr;
        logic        dw;
        logic [7:0]  da;
        logic [31:0] wd;
        logic [1:0]  g;
        logic [1:0]  rv;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic ir, input logic [7:0] ia,
                                input logic dr, input logic dw,
                                input logic [7:0] da,
                                input logic [31:0] wd,
                                input logic [1:0] g, input logic [1:0] rv,
                                input logic [31:0] rd);
        vec_t v;
        v.ir = ir; v.ia = ia; v.dr = dr; v.dw = dw;
        v.da = da; v.wd = wd; v.g = g; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic drive(input logic ir, input logic [7:0] ia,
                         input logic dr, input logic dw,
                         input logic [7:0] da, input logic [31:0] wd);
        @(negedge clk);
        i_req = ir; i_addr = {24'h0, ia};
        d_req = dr; d_we = dw; d_addr = {24'h0, da}; d_wdata = wd;
        #2;
    endtask

    task automatic check_row(input string t, input vec_t v);
        logic        eig, edg, ewe;
        logic [31:0] ea, ewd;
        eig = (v.g == 2'd1);
        edg = (v.g == 2'd2);
        ewe = edg & v.dw;
        ea  = eig ? {24'h0, v.ia} : (edg ? {24'h0, v.da} : 32'h0);
        ewd = edg ? v.wd : 32'h0;
        chk({t, " gnt"}, {30'h0, i_gnt, d_gnt}, {30'h0, eig, edg});
        chk({t, " stall"}, {30'h0, i_stall, d_stall},
            {30'h0, v.ir & ~eig, v.dr & ~edg});
        chk({t, " mem_we"}, {31'h0, mem_we}, {31'h0, ewe});
        chk({t, " mem_addr"}, mem_addr, ea);
        chk({t, " mem_wdata"}, mem_wdata, ewd);
        chk({t, " rvalid"}, {30'h0, i_rvalid, d_rvalid},
            {30'h0, v.rv == 2'd1, v.rv == 2'd2});
        chk({t, " i_rdata"}, i_rdata, (v.rv == 2'd1) ? v.rd : 32'h0);
        chk({t, " d_rdata"}, d_rdata, (v.rv == 2'd2) ? v.rd : 32'h0);
    endtask

    vec_t vq[$];
    vec_t v;

    initial begin
        for (int k = 0; k < 256; k++) mem[k] = '0;
        mem[8'h10] = 32'hABCD;
        mem[8'h04] = 32'h1111;
        mem[8'h08] = 32'h2222;

        // single fetch, then tie-break with starvation
        vq.push_back(mk(1, 8'h10, 0, 0, 8'h00, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 32'hABCD));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 0, 0));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 1, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 1, 32'h1111));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 1, 2, 32'h2222));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 32'h1111));
        // write then read-back of the same address
        vq.push_back(mk(0, 8'h00, 1, 1, 8'h20, 32'h5A5A, 2, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h20, 0, 2, 0, 0));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 2, 32'h5A5A));
        // alternating single-port reads
        vq.push_back(mk(1, 8'h04, 0, 0, 8'h00, 0, 1, 0, 0));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h08, 0, 2, 1, 32'h1111));
        vq.push_back(mk(1, 8'h04, 0, 0, 8'h00, 0, 1, 2, 32'h2222));
        vq.push_back(mk(0, 8'h00, 1, 0, 8'h08, 0, 2, 1, 32'h1111));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 2, 32'h2222));
        // starvation count holds while fetch is idle
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 0, 0));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        for (int k = 0; k < 5; k++)
            vq.push_back(mk(0, 8'h00, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 2, 2, 32'h2222));
        vq.push_back(mk(1, 8'h04, 1, 0, 8'h08, 0, 1, 2, 32'h2222));
        vq.push_back(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 32'h1111));

        // reset state
        #2;
        chk("rst rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        chk("rst i_rdata", i_rdata, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            drive(v.ir, v.ia, v.dr, v.dw, v.da, v.wd);
            check_row($sformatf("row%0d", k), v);
        end

        // saturate the counter, then reset on a fetch grant
        for (int k = 0; k < 3; k++) begin
            drive(1, 8'h04, 1, 0, 8'h08, 0);
            chk($sformatf("pre-rst D%0d", k), {30'h0, i_gnt, d_gnt}, 32'h1);
        end
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h04; d_req = 1'b0;
        rst = 1'b1;
        #2;
        chk("rst I gnt", {30'h0, i_gnt, d_gnt}, 32'h2);
        chk("rst clears d_rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        chk("rst d_rdata", d_rdata, 32'h0);
        drive(0, 8'h00, 1, 1, 8'h30, 32'h7777);
        chk("rst D gnt", {30'h0, i_gnt, d_gnt}, 32'h1);
        chk("rst mem_we masked", {31'h0, mem_we}, 32'h0);
        chk("rst rvalid hold", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #2;
        chk("post-rst no rvalid", {30'h0, i_rvalid, d_rvalid}, 32'h0);
        drive(1, 8'h04, 1, 0, 8'h30, 0);
        chk("post-rst dual D", {30'h0, i_gnt, d_gnt}, 32'h1);
        chk("post-rst i_stall", {31'h0, i_stall}, 32'h1);
        drive(0, 8'h00, 0, 0, 8'h00, 0);
        chk("masked write rv", {30'h0, i_rvalid, d_rvalid}, 32'h1);
        chk("masked write data", d_rdata, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive instruction-port denials after which the instruction port wins.
REQ-002 Parameter CNT_W, default 2: width of the starvation counter; it SHALL satisfy 2^CNT_W > STARVE_MAX.
REQ-003 Port iw_clk  in  1  single clock; all state updates on its rising edge.
REQ-004 Port iw_rst  in  1  asynchronous, active-high reset.
REQ-005 Port iw_i_req  in  1  instruction-fetch read request.
REQ-006 Port iw_i_addr  in  `SIZE_ADDR  instruction-fetch address.
REQ-007 Port ow_i_gnt  out  1  instruction request accepted this cycle.
REQ-008 Port ow_i_stall  out  1  equals iw_i_req & ~ow_i_gnt.
REQ-009 Port ow_i_rvalid  out  1  instruction read data valid.
REQ-010 Port ow_i_rdata  out  `SIZE_DATA  instruction read data.
REQ-011 Port iw_d_req  in  1  data-access request.
REQ-012 Port iw_d_we  in  1  data access is a write.
REQ-013 Port iw_d_addr  in  `SIZE_ADDR  data address.
REQ-014 Port iw_d_wdata  in  `SIZE_DATA  data write value.
REQ-015 Port ow_d_gnt  out  1  data request accepted this cycle.
REQ-016 Port ow_d_stall  out  1  equals iw_d_req & ~ow_d_gnt.
REQ-017 Port ow_d_rvalid  out  1  data read data valid.
REQ-018 Port ow_d_rdata  out  `SIZE_DATA  data read data.
REQ-019 Port ow_mem_we, ow_mem_addr, ow_mem_wdata  out  1/`SIZE_ADDR/`SIZE_DATA  shared memory control, address and write data.
REQ-020 Port iw_mem_rdata  in  `SIZE_DATA  shared memory read data, registered in the memory with one-cycle latency.

Function
REQ-021 Grants SHALL be combinational in the request cycle; at most one of ow_i_gnt and ow_d_gnt SHALL be high in any cycle.
REQ-022 Priority: when only one port requests, that port is granted; when both request, the data port wins unless r_starve >= STARVE_MAX, in which case the instruction port wins.
REQ-023 r_starve: increments (saturating at STARVE_MAX) on each cycle with iw_i_req & ~ow_i_gnt; clears to 0 on any ow_i_gnt; holds when iw_i_req is low.
REQ-024 Memory mux: ow_mem_addr is iw_d_addr when ow_d_gnt, iw_i_addr when ow_i_gnt, and 0 when idle.
REQ-025 ow_mem_we = ow_d_gnt & iw_d_we; ow_mem_wdata = iw_d_wdata when ow_d_gnt, else 0.
REQ-026 Response tracking: a registered owner tag {none, I, D} SHALL be captured each cycle; I on ow_i_gnt, D on ow_d_gnt & ~iw_d_we, none otherwise. A granted write SHALL produce no rvalid.
REQ-027 ow_i_rvalid is high exactly one cycle after an instruction grant; ow_d_rvalid is high exactly one cycle after a data read grant. Read latency SHALL be 1 cycle.
REQ-028 ow_i_rdata / ow_d_rdata SHALL equal iw_mem_rdata while the matching rvalid is high, and 0 otherwise.
REQ-029 Back-to-back grants SHALL be supported every cycle; the response for cycle N's grant and cycle N+1's grant SHALL not interfere.
REQ-030 A data write followed next cycle by a read of the same address SHALL return the written value (memory write-first ordering is relied on; no bypass in this block).

Reset
REQ-031 While iw_rst is high: r_starve = 0, owner tag = none, ow_i_rvalid = ow_d_rvalid = 0, both rdata outputs 0.
REQ-032 Grants remain combinational during reset, but ow_mem_we SHALL be forced to 0 while iw_rst is high.
REQ-033 A read granted in the cycle reset asserts SHALL produce no rvalid after reset releases.
REQ-034 After reset deassertion, the first cycle with both requests high SHALL grant the data port.

Verification
REQ-035 Only i_req, addr 0x10, memory returns 0xABCD -> i_gnt same cycle, i_rvalid next cycle with i_rdata 0xABCD, d_rvalid 0.
REQ-036 Both requests held high, STARVE_MAX=3 -> grant sequence D,D,D,I,D,D,D,I; i_stall high on each D-grant cycle.
REQ-037 Data write addr 0x20 data 0x5A5A, then data read addr 0x20 -> mem_we high first cycle only, d_rvalid second+1 cycle with 0x5A5A, no rvalid after the write.
REQ-038 Alternating I read (0x04) and D read (0x08) each cycle -> rvalid on correct port each following cycle, never both high.
REQ-039 Assert iw_rst in the cycle of an I grant -> i_rvalid stays 0, r_starve 0; first post-reset dual request grants D.
REQ-040 i_req low for 5 cycles with d_req high after 2 denials -> r_starve holds at 2, reaches 3 after one more denial, next dual request grants I.
